// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-point radix-2 DIF FFT address generator.
package fft_pkg;

  localparam int FFT_N      = 16;
  localparam int FFT_LOG2N  = 4;
  localparam int GROUP_BFLY = 4;

  typedef enum logic [1:0] {
    ADDR_IDLE    = 2'b00,
    ADDR_LOAD_AB = 2'b01,
    ADDR_LOAD_TW = 2'b10,
    ADDR_WRITE   = 2'b11
  } addr_mode_e;

  // Bit-reversed index used for natural-order readout of a DIF result.
  function automatic logic [3:0] bit_rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

endpackage

// File: rtl/fft_addr_gen_if.sv
// Controller-facing bundle of the FFT address generator.
interface fft_addr_gen_if;
  import fft_pkg::*;

  addr_mode_e addr_mode;
  logic       read_enable;
  logic       write_enable;
  logic       output_ena;
  logic [3:0] sram_addr;
  logic [2:0] twiddle_addr;
  logic [2:0] samples_in_count_out;
  logic       iteration_strobe;
  logic       stage_done;
  logic       output_done;
  logic [1:0] stage;

  modport master (
    output addr_mode, read_enable, write_enable, output_ena,
    input  sram_addr, twiddle_addr, samples_in_count_out,
    input  iteration_strobe, stage_done, output_done, stage
  );

  modport slave (
    input  addr_mode, read_enable, write_enable, output_ena,
    output sram_addr, twiddle_addr, samples_in_count_out,
    output iteration_strobe, stage_done, output_done, stage
  );

endinterface

// File: rtl/fft_bfly_addr.sv
// Maps (stage, butterfly, A/B select) to the in-place data address and
// twiddle index. All spans are powers of two, so the divide/modulo of the
// addressing formula reduce to shifts and masks.
module fft_bfly_addr (
  input  logic [1:0] stage_i,
  input  logic [2:0] bfly_i,
  input  logic       sel_b_i,
  output logic [3:0] addr_o,
  output logic [2:0] tw_o
);

  logic [3:0] span;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] tw_full;

  // Split the butterfly index into block number and offset within the span.
  always_comb begin
    span    = 4'd8 >> stage_i;
    lo      = {1'b0, bfly_i} & (span - 4'd1);
    hi      = ({1'b0, bfly_i} >> (2'd3 - stage_i)) << (3'd4 - {1'b0, stage_i});
    addr_o  = (hi | lo) + (sel_b_i ? span : 4'd0);
    tw_full = lo << stage_i;
    tw_o    = tw_full[2:0];
  end

endmodule

// File: rtl/fft_addr_gen.sv
// Address/sequence generator for an in-place 16-point radix-2 DIF FFT.
// Counters are registered; all outputs are combinational from those
// counters and the current mode/enables.
module fft_addr_gen (
  input  logic           clk,
  input  logic           rst,
  fft_addr_gen_if.slave  bus
);
  import fft_pkg::*;

  logic [2:0] ld_cnt_q,  ld_cnt_d;
  logic [1:0] tw_cnt_q,  tw_cnt_d;
  logic [2:0] wb_cnt_q,  wb_cnt_d;
  logic [3:0] out_cnt_q, out_cnt_d;
  logic       gb_q,      gb_d;        // 1 means group base 4
  logic [1:0] stage_q,   stage_d;
  logic       stage_done_q, stage_done_d;

  logic       ld_go, tw_go, wb_go, ro_go;
  logic       grp_done, ro_last;
  logic [2:0] seq_cnt;
  logic [2:0] bfly;
  logic [3:0] bfly_addr;
  logic [2:0] bfly_tw;

  // Decide which sequence, if any, is qualified this cycle.
  always_comb begin
    ld_go    = (bus.addr_mode == ADDR_LOAD_AB) && bus.read_enable;
    tw_go    = (bus.addr_mode == ADDR_LOAD_TW) && bus.read_enable;
    wb_go    = (bus.addr_mode == ADDR_WRITE)   && bus.write_enable;
    ro_go    = (bus.addr_mode == ADDR_IDLE)    && bus.output_ena && stage_done_q;
    grp_done = wb_go && (wb_cnt_q == 3'd7) && gb_q;
    ro_last  = ro_go && (out_cnt_q == 4'd15);
    // Twiddle loads step one butterfly per cycle; A/B sequences two cycles each.
    if (wb_go)      seq_cnt = wb_cnt_q;
    else if (tw_go) seq_cnt = {tw_cnt_q, 1'b0};
    else            seq_cnt = ld_cnt_q;
    bfly = {gb_q, seq_cnt[2:1]};
  end

  fft_bfly_addr u_bfly (
    .stage_i (stage_q),
    .bfly_i  (bfly),
    .sel_b_i (seq_cnt[0]),
    .addr_o  (bfly_addr),
    .tw_o    (bfly_tw)
  );

  assign bus.sram_addr            = (ld_go || wb_go) ? bfly_addr :
                                    ro_go ? bit_rev4(out_cnt_q) : 4'd0;
  assign bus.twiddle_addr         = tw_go ? bfly_tw : 3'd0;
  assign bus.samples_in_count_out = ld_cnt_q;
  assign bus.iteration_strobe     = grp_done;
  assign bus.stage_done           = stage_done_q;
  assign bus.output_done          = ro_last;
  assign bus.stage                = stage_q;

  // Next-state of every counter; unqualified cycles hold everything.
  always_comb begin
    ld_cnt_d     = ld_cnt_q;
    tw_cnt_d     = tw_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    out_cnt_d    = out_cnt_q;
    gb_d         = gb_q;
    stage_d      = stage_q;
    stage_done_d = stage_done_q;
    if (ld_go) ld_cnt_d = ld_cnt_q + 3'd1;
    if (tw_go) tw_cnt_d = tw_cnt_q + 2'd1;
    if (wb_go) begin
      wb_cnt_d = wb_cnt_q + 3'd1;
      if (wb_cnt_q == 3'd7) begin
        gb_d = ~gb_q;
        if (gb_q) begin
          stage_d = stage_q + 2'd1;
          if (stage_q == 2'd3) stage_done_d = 1'b1;
        end
      end
    end
    if (ro_go) begin
      out_cnt_d = out_cnt_q + 4'd1;
      if (ro_last) begin
        out_cnt_d    = 4'd0;
        gb_d         = 1'b0;
        stage_d      = 2'd0;
        stage_done_d = 1'b0;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q     <= 3'd0;
      tw_cnt_q     <= 2'd0;
      wb_cnt_q     <= 3'd0;
      out_cnt_q    <= 4'd0;
      gb_q         <= 1'b0;
      stage_q      <= 2'd0;
      stage_done_q <= 1'b0;
    end else begin
      ld_cnt_q     <= ld_cnt_d;
      tw_cnt_q     <= tw_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      out_cnt_q    <= out_cnt_d;
      gb_q         <= gb_d;
      stage_q      <= stage_d;
      stage_done_q <= stage_done_d;
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen: stimulus pushes expected outputs from a plain
// arithmetic model into a queue; a negedge monitor pops and compares.
module tb_fft_addr_gen;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_addr_gen_if bus();

  fft_addr_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int sram;
    int tw;
    int cnt;
    int strobe;
    int done;
    int odone;
    int stage;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model state, in the specification's own terms.
  int m_ld = 0, m_tw = 0, m_wb = 0, m_out = 0, m_gb = 0, m_stage = 0, m_done = 0;

  function automatic int ab_addr(int s, int b, int sel);
    int span;
    span = 8 >> s;
    return (b / span) * 2 * span + (b % span) + (sel != 0 ? span : 0);
  endfunction

  function automatic int tw_idx(int s, int b);
    int span;
    span = 8 >> s;
    return (b % span) << s;
  endfunction

  function automatic int bitrev(int x);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (((x >> i) & 1) != 0) r = r | (1 << (3 - i));
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; ovr >= 0 pins the expected sram_addr to a
  // hand-written value.
  task automatic cycle(input int mode, input int re, input int we, input int oe,
                       input int r, input int ovr = -1);
    exp_t e;
    int ld, tw, wb, ro;
    @(posedge clk);
    #1;
    rst              = (r != 0);
    bus.addr_mode    = addr_mode_e'(mode[1:0]);
    bus.read_enable  = (re != 0);
    bus.write_enable = (we != 0);
    bus.output_ena   = (oe != 0);
    ld = (mode == 1 && re != 0);
    tw = (mode == 2 && re != 0);
    wb = (mode == 3 && we != 0);
    ro = (mode == 0 && oe != 0 && m_done != 0);
    if (ld != 0)      e.sram = ab_addr(m_stage, m_gb + m_ld / 2, m_ld % 2);
    else if (wb != 0) e.sram = ab_addr(m_stage, m_gb + m_wb / 2, m_wb % 2);
    else if (ro != 0) e.sram = bitrev(m_out);
    else              e.sram = 0;
    if (ovr >= 0) e.sram = ovr;
    e.tw     = (tw != 0) ? tw_idx(m_stage, m_gb + m_tw) : 0;
    e.cnt    = m_ld;
    e.strobe = (wb != 0 && m_wb == 7 && m_gb == 4) ? 1 : 0;
    e.done   = m_done;
    e.odone  = (ro != 0 && m_out == 15) ? 1 : 0;
    e.stage  = m_stage;
    q.push_back(e);
    if (r != 0) begin
      m_ld = 0; m_tw = 0; m_wb = 0; m_out = 0; m_gb = 0; m_stage = 0; m_done = 0;
    end else begin
      if (ld != 0) m_ld = (m_ld + 1) % 8;
      if (tw != 0) m_tw = (m_tw + 1) % 4;
      if (wb != 0) begin
        if (m_wb == 7) begin
          if (m_gb == 0) m_gb = 4;
          else begin
            m_gb = 0;
            if (m_stage == 3) begin m_stage = 0; m_done = 1; end
            else m_stage = m_stage + 1;
          end
        end
        m_wb = (m_wb + 1) % 8;
      end
      if (ro != 0) begin
        if (m_out == 15) begin
          m_out = 0; m_gb = 0; m_stage = 0; m_done = 0;
        end else m_out = m_out + 1;
      end
    end
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sram_addr",            int'(bus.sram_addr),            e.sram);
      chk("twiddle_addr",         int'(bus.twiddle_addr),         e.tw);
      chk("samples_in_count_out", int'(bus.samples_in_count_out), e.cnt);
      chk("iteration_strobe",     int'(bus.iteration_strobe),     e.strobe);
      chk("stage_done",           int'(bus.stage_done),           e.done);
      chk("output_done",          int'(bus.output_done),          e.odone);
      chk("stage",                int'(bus.stage),                e.stage);
    end
  end

  int s1_tab[8]  = '{0, 8, 1, 9, 2, 10, 3, 11};
  int s2_tab[8]  = '{8, 10, 9, 11, 12, 14, 13, 15};
  int ro_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  initial begin
    int wait_cnt;
    bus.addr_mode    = ADDR_IDLE;
    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
    bus.output_ena   = 1'b0;
    rst              = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state
    cycle(0, 0, 0, 0, 0);
    // Stage-0 load sequence, then wrap of the load count
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 0, s1_tab[i]);
    cycle(0, 0, 0, 0, 0);
    // Stage 0 write-back (strobe on 16th), stage 1 write-back, half of stage 2
    for (int i = 0; i < 16; i++) cycle(3, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) cycle(3, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++)  cycle(3, 1, 1, 0, 0);
    // Stage 2, group 4: twiddles then A/B sequence
    for (int i = 0; i < 4; i++) cycle(2, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 1, 0, 0, s2_tab[i]);
    // Reset mid write-back of stage 2
    for (int i = 0; i < 3; i++) cycle(3, 0, 1, 0, 0);
    cycle(3, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 8);
    // Illegal readout and paused load
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, s1_tab[i]);
    cycle(0, 1, 0, 1, 0);
    cycle(2, 0, 1, 0, 0);
    cycle(1, 1, 0, 0, 0, 9);
    for (int i = 4; i < 8; i++) cycle(1, 1, 0, 0, 0, s1_tab[i]);
    // Full 4-stage run with interleaved idle cycles, then readout
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 64; i++) begin
      cycle(3, 0, 1, 0, 0);
      if (i % 7 == 3) cycle(0, 1, 0, 0, 0);
    end
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 0, ro_tab[i]);
    cycle(0, 0, 0, 1, 0);
    // Randomized traffic, biased toward write-back
    for (int i = 0; i < 600; i++) begin
      int m, re, we, oe, r;
      m  = $urandom_range(0, 3);
      re = $urandom_range(0, 1);
      we = $urandom_range(0, 1);
      oe = $urandom_range(0, 1);
      r  = ($urandom_range(0, 127) == 0) ? 1 : 0;
      if ($urandom_range(0, 2) != 0) begin m = 3; we = 1; end
      if (m_done != 0 && $urandom_range(0, 1) != 0) begin m = 0; oe = 1; end
      cycle(m, re, we, oe, r);
    end

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 addr_mode  input  2  operating mode from the main controller.
- 00 idle/readout
- 01 load A/B
- 10 load twiddle
- 11 write-back
REQ-004 read_enable  input  1  SRAM read cycle in progress.
REQ-005 write_enable  input  1  SRAM write cycle in progress.
REQ-006 output_ena  input  1  result readout cycle in progress.
REQ-007 sram_addr  output  4  data SRAM address (16-point FFT, in-place).
REQ-008 twiddle_addr  output  3  twiddle ROM index 0..7.
REQ-009 samples_in_count_out  output  3  A/B load count within the current group.
REQ-010 iteration_strobe  output  1  one-cycle pulse when a stage finishes write-back.
REQ-011 stage_done  output  1  level, high once all 4 stages are complete.
REQ-012 output_done  output  1  one-cycle pulse on the last readout address.
REQ-013 stage  output  2  current stage index s, 0..3.

Function
REQ-014 Addressing scheme: 16-point radix-2 DIF.
- 4 stages, 8 butterflies per stage, processed in 2 groups of 4 butterflies.
- Group base gb is 0 or 4.
REQ-015 Butterfly b = gb + k (k = 0..3) in stage s:
- span = 8 >> s
- A = (b / span) * 2 * span + (b mod span)
- B = A + span
- twiddle = (b mod span) << s
REQ-016 Outputs are combinational from registered counters and inputs (zero latency); counters advance at the clock edge ending a qualified cycle.
REQ-017 Mode 01 with read_enable (load A/B):
- sram_addr = A for even ld_cnt, B for odd ld_cnt; k = ld_cnt >> 1.
- ld_cnt increments, wrapping 7 -> 0.
- samples_in_count_out = ld_cnt.
REQ-018 Mode 10 with read_enable (load twiddle):
- twiddle_addr = twiddle of butterfly gb + tw_cnt; sram_addr = 0.
- tw_cnt (2 bit) increments, wrapping 3 -> 0.
REQ-019 Mode 11 with write_enable (write-back):
- sram_addr follows the same A/B sequence as REQ-017, indexed by wb_cnt (3 bit).
- On wb_cnt 7 -> 0 wrap, gb toggles 0 <-> 4.
- When gb returns to 0: iteration_strobe pulses for that cycle, and stage increments.
- When stage 3 completes: stage wraps to 0 and stage_done sets.
REQ-020 Mode 00 with output_ena (readout):
- sram_addr = bit_reverse(out_cnt); out_cnt 0..15 increments.
- On out_cnt = 15: output_done is high that cycle, stage_done clears next edge, and out_cnt, gb and stage return to 0.
REQ-021 Unqualified cycles: an enable in a non-matching mode, or a mode without its enable, changes no counter.
- sram_addr = 0 and twiddle_addr = 0 on those cycles.
REQ-022 read_enable and write_enable may both be high; the mode selects which one is honoured.
REQ-023 A mode change mid-group preserves all counters; the sequence resumes where it stopped.
REQ-024 Readout is ignored while stage_done = 0; the output_done pulse never occurs before all stages complete.
REQ-025 iteration_strobe and output_done are never high for more than 1 consecutive cycle.

Reset
REQ-026 While rst = 1 at a rising edge, the following clear to 0 on that edge, with any sequence in progress discarded:
- ld_cnt, tw_cnt, wb_cnt, out_cnt, gb, stage and stage_done.
REQ-027 The cycle after reset, all outputs read 0: sram_addr, twiddle_addr, samples_in_count_out, iteration_strobe, stage_done, output_done and stage.

Structure
REQ-028 Shared package fft_pkg holds:
- the addr_mode enum: ADDR_IDLE = 00, ADDR_LOAD_AB = 01, ADDR_LOAD_TW = 10, ADDR_WRITE = 11.
- constants FFT_N = 16, FFT_LOG2N = 4, GROUP_BFLY = 4.
REQ-029 One combinational sub-module, fft_bfly_addr, maps (stage, butterfly index, A/B select) to (data address, twiddle index).

Verification
REQ-030 Scenario 1 (stage-0 load): after reset, mode 01 + read_enable for 8 cycles -> sram_addr = 0,8,1,9,2,10,3,11; samples_in_count_out = 0..7 then 0.
REQ-031 Scenario 2 (stage-2 twiddles): at stage 2, group gb = 4, mode 10 for 4 cycles -> twiddle_addr = 0,4,0,4; stage-2 A/B sequence = 8,10,9,11,12,14,13,15.
REQ-032 Scenario 3 (stage completion): 16 write-back cycles in stage 0 -> iteration_strobe high only on the 16th cycle; stage = 1 afterwards.
REQ-033 Scenario 4 (full run and readout):
- Full 4-stage run -> stage_done = 1.
- 16 readout cycles -> sram_addr = 0,8,4,12,2,...,15; output_done on the 16th; stage_done = 0 after.
REQ-034 Scenario 5 (reset mid-operation): rst asserted mid write-back of stage 2 -> all outputs 0 next cycle; the next load restarts at sram_addr 0,8.
REQ-035 Scenario 6 (illegal readout and paused load):
- output_ena in mode 00 with stage_done = 0 -> no counter change, output_done stays 0.
- Switching mode 01 -> 00 after 3 loads, then back -> sequence resumes at sram_addr 9.
